// File: rtl/fifo_arb_pkg.sv
// Shared encodings and width helpers for the FIFO write-port arbiter.
// No logic; constants and elaboration-time functions only.
// No flow control of its own.
package fifo_arb_pkg;

    // Arbiter FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Requester index width: clog2(N_REQ), never below one bit
    function automatic int req_w(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

    // Burst counter width: must hold MAX_BURST itself without wrapping
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: first asserted req scanning ptr+1, ptr+2, ... mod N_REQ.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the winner is consumed.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int REQ_W = req_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [REQ_W-1:0] ptr,
    output logic [REQ_W-1:0] winner,
    output logic             any_req
);

    logic [REQ_W-1:0] idx;

    // Walk the ring starting just after ptr; modulo keeps non-power-of-2 counts correct
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = REQ_W'((int'(ptr) + i) % N_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin owner of one FIFO write port shared by N_REQ requesters, bounded bursts.
// Grant one cycle after request; words then pass combinationally (req -> fifo_we/ack).
// fifo_full stalls the owner in place: no write, no count, grant held.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  DW        = 8,
    parameter int  MAX_BURST = 4,
    localparam int REQ_W     = req_w(N_REQ),
    localparam int CNT_W     = cnt_w(MAX_BURST)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    last,
    input  logic [N_REQ*DW-1:0] din,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                fifo_we,
    output logic [DW-1:0]       fifo_din,
    input  logic                fifo_full,
    output logic [REQ_W-1:0]    owner,
    output logic                busy
);

    logic [0:0]       state;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [REQ_W-1:0] ptr;
    logic [REQ_W-1:0] pick_winner;
    logic             pick_any;
    logic             owner_req;
    logic             owner_last;
    logic             end_burst;

    fifo_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (pick_winner),
        .any_req (pick_any)
    );

    assign busy       = (state == ST_BURST);
    assign owner_req  = req[owner];
    assign owner_last = last[owner];
    assign cnt_inc    = burst_cnt + CNT_W'(1);

    // A word is written only while owning, requesting, not full and not being cleared
    assign fifo_we  = busy & owner_req & ~fifo_full & ~clr;
    assign fifo_din = din[owner*DW +: DW];

    // Burst ends on a dropped request, or on an accepted word that is last or fills the quota
    assign end_burst = ~owner_req |
                       (fifo_we & (owner_last | (cnt_inc == CNT_W'(MAX_BURST))));

    // Acknowledge only the owner, and only for a word actually written
    always_comb begin
        ack = '0;
        if (fifo_we) begin
            ack[owner] = 1'b1;
        end
    end

    // Grant FSM; clear outranks every transition and also resets the rotation pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            ptr       <= REQ_W'(N_REQ - 1);
        end else if (clr) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            ptr       <= REQ_W'(N_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state     <= ST_BURST;
                        gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_winner;
                        owner     <= pick_winner;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    if (fifo_we) begin
                        burst_cnt <= cnt_inc;
                    end
                    if (end_burst) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        owner <= '0;
                        ptr   <= owner;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
Round-robin write-port arbiter that shares one generic_fifo_dc write port between N_REQ requesters in the write-clock domain.
Grants bounded bursts. Drives the FIFO's we/din directly and qualifies every write with full, so no word is lost or duplicated.
Sits between producer blocks and the write side of the dual-clock FIFO.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, data width; matches FIFO data width
MAX_BURST, 4, maximum words accepted per grant (1..16)

Ports:
clk  in  1  write-side clock (the FIFO's wr_clk)
rst  in  1  asynchronous reset, active-low
clr  in  1  synchronous clear: abort burst, return to IDLE, reset priority pointer
req  in  N_REQ  per-requester word-valid; held until ack or voluntarily dropped
last  in  N_REQ  per-requester end-of-burst marker, qualified with req
din  in  N_REQ*DW  requester data, slice i = din[i*DW +: DW]
gnt  out  N_REQ  one-hot current owner, registered
ack  out  N_REQ  word accepted this cycle (one-hot or zero)
fifo_we  out  1  FIFO write enable (already full-qualified)
fifo_din  out  DW  FIFO write data = din slice of owner
fifo_full  in  1  FIFO full flag
owner  out  clog2(N_REQ)  index of current owner, 0 when idle
busy  out  1  high in BURST state

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, owner=0, busy=0, burst_cnt=0, ptr=N_REQ-1. Combinational outputs follow, so ack=0 and fifo_we=0.
- States: IDLE, BURST.
- IDLE:
  - if any req: winner = first asserted req scanning ptr+1, ptr+2, ... mod N_REQ.
  - Next cycle: state=BURST, gnt=onehot(winner), owner=winner, burst_cnt=0.
  - Arbitration latency is 1 cycle; no write occurs in IDLE.
- BURST, combinational outputs:
  - fifo_we = req[owner] & !fifo_full
  - ack[owner] = fifo_we; all other ack bits are 0
  - fifo_din = din slice of owner; it may be X when fifo_we=0
- BURST, on each accepted word: burst_cnt += 1.
- BURST terminates (next state IDLE, gnt=0, ptr<=owner) when any of:
  - (a) accepted word with last[owner]=1;
  - (b) accepted word makes burst_cnt == MAX_BURST;
  - (c) req[owner]=0 (no write that cycle).
- fifo_full in BURST: stall. No write, no count, grant held indefinitely while req[owner]=1. A full FIFO never causes a grant change.
- Requests from non-owners are ignored during BURST; they are served in rotation after termination.
- The IDLE bubble between bursts is mandatory: sustained throughput = MAX_BURST/(MAX_BURST+1) words/clk.
- clr=1: next state IDLE, gnt=0, burst_cnt=0, ptr=N_REQ-1.
  - Combinational fifo_we is forced 0 in the clr cycle.
  - clr has priority over all transitions.
- Reset mid-burst: gnt drops asynchronously. Any word not acked is not written; requesters re-request.
- burst_cnt width = clog2(MAX_BURST+1), and it never wraps.
- ptr wrap-around: rotation index is computed modulo N_REQ (no power-of-2 assumption).

Decomposition:
- Package fifo_arb_pkg: state encoding (IDLE=0, BURST=1) and width helper constants (REQ_W = clog2(N_REQ), CNT_W = clog2(MAX_BURST+1)).
- Sub-module fifo_rr_pick: combinational rotate-priority picker (req, ptr) -> (winner, any). Tested standalone.

Test Plan:
- Reset with req=4'b1111 held: after rst release, first gnt=4'b0001 one cycle later. Subsequent bursts grant 0,1,2,3,0 in order, each of 4 words when last=0, with one idle cycle between.
- Requester 2 only, req=1 for 2 words with last on word 2: exactly 2 fifo_we pulses, data matches din slice 2 in order. Then IDLE, with ptr=2 so requester 3 wins next if both 3 and 0 request.
- fifo_full asserted for 5 cycles mid-burst after word 1: gnt[1] held, fifo_we=0 and ack=0 for those 5 cycles. Remaining 3 words are written after full drops; total 4 words, none duplicated.
- Owner drops req after 1 word (MAX_BURST=4): burst ends with burst_cnt=1, gnt clears next cycle, no spurious write.
- clr pulsed in the cycle requester 3 would be acked: no write that cycle, state=IDLE, and next grant goes to the lowest pending requester (ptr reset).
- Async rst pulse mid-burst (not clock-aligned): gnt, ack and fifo_we go 0 immediately. A scoreboard on FIFO output (fed by fifo_we/fifo_din into generic_fifo_dc) shows no missing or extra words across 1000 random req/last/full cycles.
